// File: rtl/approx_mult_err_scan.sv
// approx_mult_err_scan: sweeps operands through an external multiplier and gathers error stats.
// Random LFSR mode is built only when APPROX_MULT_ERR_SCAN_LFSR_EN is defined.
module approx_mult_err_scan #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DUT_LAT = 0,
   parameter int unsigned SEED    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [2*WIDTH-1:0]   num_samples,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   input  logic [2*WIDTH-1:0]   dut_y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH:0]     err_count,
   output logic [2*WIDTH:0]     ok_count,
   output logic [2*WIDTH-1:0]   max_err,
   output logic [4*WIDTH-1:0]   sum_abs_err
);
   localparam int unsigned PW  = 2 * WIDTH;
   localparam int unsigned CW  = 2 * WIDTH + 1;
   localparam int unsigned SW  = 4 * WIDTH;
   localparam int unsigned SW1 = SW + 1;
   localparam logic [2:0] DrainLast = (DUT_LAT == 0) ? 3'd0 : 3'(DUT_LAT - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t        state_q, state_d;
   logic [2:0]    drain_q;
   logic          launch, issue, idle_run, at_last;
   logic [PW-1:0] pair, pair_next, load_pair, prod;
   logic          cmp_valid;
   logic [PW-1:0] cmp_exp, diff;
   logic [SW:0]   sum_ext;

   assign pair   = {op_a, op_b};
   assign prod   = PW'(op_a) * PW'(op_b);
   assign launch = (state_q == StIdle) && start;

`ifdef APPROX_MULT_ERR_SCAN_LFSR_EN
   // Right-shifting Galois masks for maximal-length sequences, indexed by register width.
   localparam logic [63:0] MaskAll =
      (PW == 4)  ? 64'hC      : (PW == 8)  ? 64'hB8     : (PW == 12) ? 64'hE08 :
      (PW == 16) ? 64'hB400   : (PW == 20) ? 64'h90000  : (PW == 24) ? 64'hE10000 :
      64'h80200003;
   localparam logic [PW-1:0] LfsrMask = MaskAll[PW-1:0];

   logic          rnd_q;
   logic [PW-1:0] rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_q <= 1'b0;
         rem_q <= '0;
      end else if (launch) begin
         rnd_q <= mode;
         rem_q <= num_samples;
      end else if (issue) begin
         rem_q <= rem_q - PW'(1);
      end
   end

   assign idle_run  = rnd_q && (rem_q == '0);
   assign at_last   = rnd_q ? (rem_q == PW'(1)) : (&pair);
   assign pair_next = rnd_q ? ((pair >> 1) ^ (pair[0] ? LfsrMask : '0)) : pair + PW'(1);
   assign load_pair = mode ? PW'(SEED) : '0;
`else
   logic unused_cfg;
   assign unused_cfg = ^{mode, num_samples, PW'(SEED)};
   assign idle_run   = 1'b0;
   assign at_last    = &pair;
   assign pair_next  = pair + PW'(1);
   assign load_pair  = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun: begin
            issue = !idle_run;
            if (idle_run || at_last) state_d = (DUT_LAT == 0) ? StDone : StDrain;
         end
         StDrain: if (drain_q == DrainLast) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    drain_q <= 3'd0;
      else if (state_q == StRun)  drain_q <= 3'd0;
      else if (state_q == StDrain) drain_q <= drain_q + 3'd1;
   end

   // The final pair is not advanced past, so the operands keep it once the scan ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    {op_a, op_b} <= '0;
      else if (launch)            {op_a, op_b} <= load_pair;
      else if (issue && !at_last) {op_a, op_b} <= pair_next;
   end

   if (DUT_LAT == 0) begin : g_comb
      assign cmp_valid = issue;
      assign cmp_exp   = prod;
   end else begin : g_pipe
      logic [DUT_LAT-1:0] vld_q;
      logic [PW-1:0]      exp_q [DUT_LAT];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < DUT_LAT; i++) vld_q[i] <= vld_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         exp_q[0] <= prod;
         for (int i = 1; i < DUT_LAT; i++) exp_q[i] <= exp_q[i-1];
      end

      assign cmp_valid = vld_q[DUT_LAT-1];
      assign cmp_exp   = exp_q[DUT_LAT-1];
   end

   assign diff    = (dut_y >= cmp_exp) ? dut_y - cmp_exp : cmp_exp - dut_y;
   assign sum_ext = {1'b0, sum_abs_err} + SW1'(diff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst || launch) begin
         err_count   <= '0;
         ok_count    <= '0;
         max_err     <= '0;
         sum_abs_err <= '0;
      end else if (cmp_valid) begin
         if (diff != '0) begin
            if (err_count != '1) err_count <= err_count + CW'(1);
         end else if (ok_count != '1) begin
            ok_count <= ok_count + CW'(1);
         end
         if (diff > max_err) max_err <= diff;
         sum_abs_err <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
      end
   end

   assign busy = (state_q == StRun) || (state_q == StDrain);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_approx_mult_err_scan.sv
// Bench for approx_mult_err_scan: three WIDTH=8 scanners in one sweep plus a WIDTH=4 scanner
// checked against a plain-arithmetic model over a table of DUT behaviours.
module tb_approx_mult_err_scan;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst8 = 1'b0, rst4 = 1'b0, start8 = 1'b0, start4 = 1'b0, mode4 = 1'b0;
   logic [7:0] ns4 = 8'd0;

   // WIDTH=8 instances: a = exact LAT0, z = zero LAT0, x = exact^1 LAT2
   logic [7:0]  a_a, a_b, z_a, z_b, x_a, x_b;
   logic [15:0] y_a, y_z, y_x, px1, px2;
   logic        busy_a, done_a, busy_z, done_z, busy_x, done_x;
   logic [16:0] err_a, ok_a, err_z, ok_z, err_x, ok_x;
   logic [15:0] max_a, max_z, max_x;
   logic [31:0] sum_a, sum_z, sum_x;

   assign y_a = 16'(a_a) * 16'(a_b);
   assign y_z = 16'd0;
   assign y_x = px2;
   always @(posedge clk) begin
      px1 <= (16'(x_a) * 16'(x_b)) ^ 16'd1;
      px2 <= px1;
   end

   approx_mult_err_scan #(.WIDTH(8), .DUT_LAT(0), .SEED(1)) u_a (
      .clk(clk), .rst(rst8), .start(start8), .mode(1'b0), .num_samples(16'd0),
      .op_a(a_a), .op_b(a_b), .dut_y(y_a), .busy(busy_a), .done(done_a),
      .err_count(err_a), .ok_count(ok_a), .max_err(max_a), .sum_abs_err(sum_a));
   approx_mult_err_scan #(.WIDTH(8), .DUT_LAT(0), .SEED(1)) u_z (
      .clk(clk), .rst(rst8), .start(start8), .mode(1'b0), .num_samples(16'd0),
      .op_a(z_a), .op_b(z_b), .dut_y(y_z), .busy(busy_z), .done(done_z),
      .err_count(err_z), .ok_count(ok_z), .max_err(max_z), .sum_abs_err(sum_z));
   approx_mult_err_scan #(.WIDTH(8), .DUT_LAT(2), .SEED(1)) u_x (
      .clk(clk), .rst(rst8), .start(start8), .mode(1'b0), .num_samples(16'd0),
      .op_a(x_a), .op_b(x_b), .dut_y(y_x), .busy(busy_x), .done(done_x),
      .err_count(err_x), .ok_count(ok_x), .max_err(max_x), .sum_abs_err(sum_x));

   // WIDTH=4 instance, LAT1, behaviour selected by kind4
   logic [3:0] a4, b4;
   logic [7:0] y4, max4;
   logic       busy4, done4;
   logic [8:0] err4, ok4;
   logic [15:0] sum4;
   logic [7:0] noise [256];
   int         kind4 = 0;

   function automatic logic [7:0] dutf(input int kind, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'(a) * 8'(b);
      case (kind)
         0:       return p;
         1:       return 8'd0;
         2:       return p + 8'd1;
         default: return p ^ noise[{a, b}];
      endcase
   endfunction

   always @(posedge clk) y4 <= dutf(kind4, a4, b4);

   approx_mult_err_scan #(.WIDTH(4), .DUT_LAT(1), .SEED(37)) u_4 (
      .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .num_samples(ns4),
      .op_a(a4), .op_b(b4), .dut_y(y4), .busy(busy4), .done(done4),
      .err_count(err4), .ok_count(ok4), .max_err(max4), .sum_abs_err(sum4));

   typedef struct {
      int     kind;
      int     e;
      int     o;
      int     mx;
      longint s;
   } vec_t;

   vec_t tbl[4];
   vec_t vtmp;
   int   n_chk = 0, n_pass = 0;
   int   ba, bz, bx, da, dz, dx, ca, cx, nd, nb, nr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Maximal-length 8-bit Galois LFSR, right-shifting, taps 8,6,5,4.
   function automatic int lstep(input int x);
      return (x >> 1) ^ (((x & 1) != 0) ? 'hB8 : 0);
   endfunction

   task automatic model4(input int kind, input bit rnd, input int n, output vec_t v);
      int p, cnt, pr, y, d;
      v.kind = kind; v.e = 0; v.o = 0; v.mx = 0; v.s = 0;
      p   = rnd ? 37 : 0;
      cnt = rnd ? n : 256;
      for (int k = 0; k < cnt; k++) begin
         pr = (p >> 4) * (p & 15);
         y  = int'(dutf(kind, 4'(p >> 4), 4'(p)));
         d  = (y > pr) ? y - pr : pr - y;
         if (d != 0) v.e++; else v.o++;
         if (d > v.mx) v.mx = d;
         v.s += d;
         p = rnd ? lstep(p) : p + 1;
      end
   endtask

   task automatic scan4(input string tag, input bit rnd, input int n, input int exp_busy,
                        input vec_t v);
      int  bc;
      bit  got;
      bc = 0;
      got = 1'b0;
      kind4 = v.kind;
      mode4 = rnd;
      ns4 = 8'(n);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      mode4 = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
         if (busy4) bc++;
         if (done4) got = 1'b1;
         else tick();
      end
      check({tag, "_done_seen"}, got, 1);
      check({tag, "_busy_cycles"}, bc, exp_busy);
      tick();
      check({tag, "_done_pulse"}, done4, 0);
      check({tag, "_err"}, err4, v.e);
      check({tag, "_ok"}, ok4, v.o);
      check({tag, "_max"}, max4, v.mx);
      check({tag, "_sum"}, sum4, v.s);
   endtask

   initial begin
      foreach (noise[i]) noise[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      tbl[0] = '{kind: 0, e: 0,   o: 256, mx: 0,   s: 0};
      tbl[1] = '{kind: 1, e: 225, o: 31,  mx: 225, s: 14400};
      tbl[2] = '{kind: 2, e: 256, o: 0,   mx: 1,   s: 256};
      model4(3, 1'b0, 0, tbl[3]);

      #2 rst8 = 1'b1; rst4 = 1'b1;
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_x, 0);
      check("rst_ops", {a_a, a_b}, 0);
      check("rst_stats4", {err4, ok4, max4, sum4}, 0);
      tick();
      rst8 = 1'b0; rst4 = 1'b0;
      tick();

      // Abort a scan with reset at RUN cycle 1000.
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (1000) tick();
      check("mid_busy", busy_a, 1);
      rst8 = 1'b1;
      #1;
      check("abort_busy", {busy_a, busy_z, busy_x}, 0);
      check("abort_ops", {a_a, a_b, z_a, z_b}, 0);
      check("abort_err_z", err_z, 0);
      check("abort_ok_a", ok_a, 0);
      check("abort_sum_z", sum_z, 0);
      check("abort_max_z", max_z, 0);
      tick();
      rst8 = 1'b0;
      nd = 0; nb = 0;
      for (int c = 0; c < 20; c++) begin
         if (done_a || done_z || done_x) nd++;
         if (busy_a || busy_z || busy_x) nb++;
         tick();
      end
      check("abort_no_done", nd, 0);
      check("abort_idle", nb, 0);

      // Full WIDTH=8 sweep on all three; stray starts in RUN and DONE/DRAIN are ignored.
      ba = 0; bz = 0; bx = 0; da = 0; dz = 0; dx = 0; ca = -1; cx = -1;
      start8 = 1'b1;
      tick();
      for (int c = 0; c < 65545; c++) begin
         start8 = (c == 500 || c == 65536);
         if (busy_a) ba++;
         if (busy_z) bz++;
         if (busy_x) bx++;
         if (done_a) begin da++; ca = c; end
         if (done_z) dz++;
         if (done_x) begin dx++; cx = c; end
         tick();
      end
      start8 = 1'b0;
      check("a_busy_cycles", ba, 65536);
      check("z_busy_cycles", bz, 65536);
      check("x_busy_cycles", bx, 65538);
      check("a_done_count", da, 1);
      check("z_done_count", dz, 1);
      check("x_done_count", dx, 1);
      check("a_done_cycle", ca, 65536);
      check("x_done_cycle", cx, 65538);
      check("end_idle", {busy_a, busy_z, busy_x}, 0);
      check("a_op_hold", {a_a, a_b}, 16'hFFFF);
      check("a_ok", ok_a, 65536);
      check("a_err", err_a, 0);
      check("a_max", max_a, 0);
      check("a_sum", sum_a, 0);
      check("z_err", err_z, 65025);
      check("z_ok", ok_z, 511);
      check("z_max", max_z, 65025);
      check("z_sum", sum_z, 64'd1065369600);
      check("x_err", err_x, 65536);
      check("x_ok", ok_x, 0);
      check("x_max", max_x, 1);
      check("x_sum", sum_x, 65536);

      // WIDTH=4 table of DUT behaviours, exhaustive.
      for (int i = 0; i < 4; i++) scan4($sformatf("w4_kind%0d", i), 1'b0, 0, 257, tbl[i]);

`ifdef APPROX_MULT_ERR_SCAN_LFSR_EN
      model4(0, 1'b1, 100, vtmp);
      check("rnd100_model_ok", vtmp.o, 100);
      scan4("rnd100_exact", 1'b1, 100, 101, vtmp);
      for (int r = 0; r < 3; r++) begin
         nr = $urandom_range(1, 200);
         model4(3, 1'b1, nr, vtmp);
         scan4($sformatf("rnd_noise%0d", r), 1'b1, nr, nr + 1, vtmp);
      end
      model4(3, 1'b1, 0, vtmp);
      scan4("rnd_zero", 1'b1, 0, 2, vtmp);
`else
      // mode/num_samples are ignored: still a full exhaustive scan.
      scan4("mode_ignored", 1'b1, 5, 257, tbl[3]);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
